// File: rtl/mux_pkg.sv
// Shared sizing and index helpers for the N-way registered channel mux.
package mux_pkg;

    localparam int MAX_N_IN = 16;
    localparam int IDX_W    = 4;

    typedef logic [IDX_W-1:0] chan_idx_t;

    function automatic int sel_width(input int n_in, input int onehot);
        if (onehot != 0) begin
            return n_in;
        end else begin
            return $clog2(n_in);
        end
    endfunction

    // Scan from the top down so the lowest set bit is the last one written.
    function automatic chan_idx_t lowest_set_idx(input logic [MAX_N_IN-1:0] vec);
        chan_idx_t idx;
        idx = {IDX_W{1'b0}};
        for (int i = MAX_N_IN - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mux_n_sel.sv
// Combinational channel picker: decodes a binary or one-hot select into one
// DATA_W slice of the flat input bus.
module mux_n_sel
    import mux_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_IN   = 4,
    parameter int ONEHOT = 0,
    localparam int SEL_W = sel_width(N_IN, ONEHOT)
) (
    input  logic [DATA_W*N_IN-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [DATA_W-1:0]      out_data
);

    localparam int EXT_W = IDX_W + 1;

    chan_idx_t w_idx;

    generate
        if (ONEHOT != 0) begin : g_onehot
            logic [MAX_N_IN-1:0] w_vec;
            assign w_vec = MAX_N_IN'(in_sel);
            assign w_idx = lowest_set_idx(w_vec);
        end else begin : g_binary
            logic [EXT_W-1:0] w_sel_ext;
            assign w_sel_ext = EXT_W'(in_sel);
            // Codes past the last channel fall back to channel 0.
            assign w_idx = (w_sel_ext < EXT_W'(N_IN)) ? w_sel_ext[IDX_W-1:0] : {IDX_W{1'b0}};
        end
    endgenerate

    // Slice out the indexed channel.
    always_comb begin
        out_data = in_data[DATA_W-1:0];
        for (int i = 1; i < N_IN; i++) begin
            if (w_idx == IDX_W'(i)) begin
                out_data = in_data[i*DATA_W +: DATA_W];
            end else begin
                out_data = out_data;
            end
        end
    end

endmodule

// File: rtl/mux_n_pipe.sv
// N-way channel mux with a registered output and one skid slot, giving full
// throughput while in_ready depends only on local state.
module mux_n_pipe
    import mux_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_IN   = 4,
    parameter int ONEHOT = 0,
    localparam int SEL_W = sel_width(N_IN, ONEHOT)
) (
    input  logic                   clk,
    input  logic                   arst_n,
    input  logic [DATA_W*N_IN-1:0] in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush
);

    logic [DATA_W-1:0] w_sel_data;
    logic              w_accept;
    logic              w_main_free;
    logic              w_main_load_in;
    logic              w_main_load_skid;
    logic              w_skid_load;
    logic              w_main_v_nxt;
    logic              w_skid_v_nxt;

    logic              r_main_v;
    logic              r_skid_v;
    logic [DATA_W-1:0] r_main_data;
    logic [SEL_W-1:0]  r_main_sel;
    logic [DATA_W-1:0] r_skid_data;
    logic [SEL_W-1:0]  r_skid_sel;

    mux_n_sel #(
        .DATA_W (DATA_W),
        .N_IN   (N_IN),
        .ONEHOT (ONEHOT)
    ) u_sel (
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_data (w_sel_data)
    );

    assign w_accept    = in_valid & ~r_skid_v;
    assign w_main_free = ~r_main_v | out_ready;

    // Route the incoming beat and any skid beat; flush overrides every move.
    always_comb begin
        w_main_load_in   = 1'b0;
        w_main_load_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_main_v_nxt     = r_main_v;
        w_skid_v_nxt     = r_skid_v;
        if (flush) begin
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else if (w_main_free) begin
            if (r_skid_v) begin
                w_main_load_skid = 1'b1;
                w_main_v_nxt     = 1'b1;
                w_skid_load      = w_accept;
                w_skid_v_nxt     = w_accept;
            end else begin
                w_main_load_in = w_accept;
                w_main_v_nxt   = w_accept;
            end
        end else begin
            w_skid_load  = w_accept;
            w_skid_v_nxt = r_skid_v | w_accept;
        end
    end

    // Occupancy flags for the main and skid slots.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else begin
            r_main_v <= w_main_v_nxt;
            r_skid_v <= w_skid_v_nxt;
        end
    end

    // Payload registers only change when a beat is actually written into them.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_main_data <= {DATA_W{1'b0}};
            r_main_sel  <= {SEL_W{1'b0}};
            r_skid_data <= {DATA_W{1'b0}};
            r_skid_sel  <= {SEL_W{1'b0}};
        end else begin
            if (w_main_load_skid) begin
                r_main_data <= r_skid_data;
                r_main_sel  <= r_skid_sel;
            end else if (w_main_load_in) begin
                r_main_data <= w_sel_data;
                r_main_sel  <= in_sel;
            end else begin
                r_main_data <= r_main_data;
                r_main_sel  <= r_main_sel;
            end
            if (w_skid_load) begin
                r_skid_data <= w_sel_data;
                r_skid_sel  <= in_sel;
            end else begin
                r_skid_data <= r_skid_data;
                r_skid_sel  <= r_skid_sel;
            end
        end
    end

    assign in_ready  = ~r_skid_v;
    assign out_valid = r_main_v;
    assign out_data  = r_main_data;
    assign out_sel   = r_main_sel;

endmodule

// File: tb/tb_mux_n_pipe.sv
// Directed bench for mux_n_pipe: scoreboard monitors on the binary instances,
// direct checks for select decoding, backpressure, flush and async reset.
module tb_mux_n_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   d_pops = 0;
    logic [31:0] qa[$];
    logic [31:0] qd[$];

    logic [63:0]  a_data;
    logic [1:0]   a_sel, a_os;
    logic [15:0]  a_od;
    logic         a_iv, a_ir, a_ov, a_or, a_fl;
    logic [47:0]  b_data;
    logic [1:0]   b_sel, b_os;
    logic [15:0]  b_od;
    logic         b_ir, b_ov;
    logic [63:0]  c_data;
    logic [3:0]   c_sel, c_os;
    logic [15:0]  c_od;
    logic         c_ir, c_ov;
    logic [127:0] d_data;
    logic [2:0]   d_sel, d_os;
    logic [15:0]  d_od;
    logic         d_iv, d_ir, d_ov, d_or;
    logic         bc_iv, bc_or, no_flush;

    mux_n_pipe #(.DATA_W(16), .N_IN(4), .ONEHOT(0)) u_a (
        .clk(clk), .arst_n(arst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(a_iv),
        .in_ready(a_ir), .out_data(a_od), .out_sel(a_os), .out_valid(a_ov),
        .out_ready(a_or), .flush(a_fl));
    mux_n_pipe #(.DATA_W(16), .N_IN(3), .ONEHOT(0)) u_b (
        .clk(clk), .arst_n(arst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(bc_iv),
        .in_ready(b_ir), .out_data(b_od), .out_sel(b_os), .out_valid(b_ov),
        .out_ready(bc_or), .flush(no_flush));
    mux_n_pipe #(.DATA_W(16), .N_IN(4), .ONEHOT(1)) u_c (
        .clk(clk), .arst_n(arst_n), .in_data(c_data), .in_sel(c_sel), .in_valid(bc_iv),
        .in_ready(c_ir), .out_data(c_od), .out_sel(c_os), .out_valid(c_ov),
        .out_ready(bc_or), .flush(no_flush));
    mux_n_pipe #(.DATA_W(16), .N_IN(8), .ONEHOT(0)) u_d (
        .clk(clk), .arst_n(arst_n), .in_data(d_data), .in_sel(d_sel), .in_valid(d_iv),
        .in_ready(d_ir), .out_data(d_od), .out_sel(d_os), .out_valid(d_ov),
        .out_ready(d_or), .flush(no_flush));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pick(input logic [127:0] bus, input int sel, input int n);
        int s;
        s = (sel >= n) ? 0 : sel;
        return bus[s*16 +: 16];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for instance A: pop on each output transfer, push on each accept.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!arst_n || a_fl) begin
            qa.delete();
        end else begin
            if (a_ov && a_or) begin
                check("a_scoreboard_nonempty", 32'(qa.size() != 0), 32'd1);
                if (qa.size() != 0) begin
                    e = qa.pop_front();
                    check("a_out_data", 32'(a_od), {16'h0000, e[15:0]});
                    check("a_out_sel", 32'(a_os), {16'h0000, e[31:16]});
                end
            end
            if (a_iv && a_ir) qa.push_back({14'h0000, a_sel, pick(128'(a_data), int'(a_sel), 4)});
        end
    end

    // Scoreboard for the streaming instance D.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!arst_n) begin
            qd.delete();
        end else begin
            if (d_ov && d_or) begin
                check("d_scoreboard_nonempty", 32'(qd.size() != 0), 32'd1);
                if (qd.size() != 0) begin
                    e = qd.pop_front();
                    d_pops++;
                    check("d_out_data", 32'(d_od), {16'h0000, e[15:0]});
                    check("d_out_sel", 32'(d_os), {16'h0000, e[31:16]});
                end
            end
            if (d_iv && d_ir) qd.push_back({13'h0000, d_sel, pick(d_data, int'(d_sel), 8)});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n = 1'b0;
        a_data = 64'h0; a_sel = 2'd0; a_iv = 1'b0; a_or = 1'b0; a_fl = 1'b0;
        b_data = {16'hB2B2, 16'hB1B1, 16'hB0B0}; b_sel = 2'd0;
        c_data = {16'hC3C3, 16'hC2C2, 16'hC1C1, 16'hC0C0}; c_sel = 4'd0;
        d_data = 128'h0; d_sel = 3'd0; d_iv = 1'b0; d_or = 1'b0;
        bc_iv = 1'b0; bc_or = 1'b0; no_flush = 1'b0;
        for (int i = 0; i < 8; i++) d_data[i*16 +: 16] = 16'hD000 + 16'(i * 273);
        #2;
        check("rst_out_valid", 32'(a_ov), 32'd0);
        check("rst_in_ready", 32'(a_ir), 32'd1);
        check("rst_out_data", 32'(a_od), 32'd0);
        check("rst_out_sel", 32'(a_os), 32'd0);
        check("rst_d_in_ready", 32'(d_ir), 32'd1);
        #10 arst_n = 1'b1;

        // Basic select, one cycle latency
        step();
        a_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}; a_sel = 2'd2; a_iv = 1'b1; a_or = 1'b1;
        step();
        a_iv = 1'b0;
        check("basic_out_valid", 32'(a_ov), 32'd1);
        check("basic_out_data", 32'(a_od), 32'h0000CCCC);
        check("basic_out_sel", 32'(a_os), 32'd2);
        step();
        check("basic_drained", 32'(a_ov), 32'd0);

        // Backpressure: A held, B in skid, C stalled
        a_or = 1'b0;
        a_data = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00}; a_sel = 2'd1; a_iv = 1'b1;
        step();
        a_data = {16'h0B03, 16'h0B02, 16'h0B01, 16'h0B00}; a_sel = 2'd3;
        step();
        a_data = {16'h0C03, 16'h0C02, 16'h0C01, 16'h0C00}; a_sel = 2'd0;
        check("bp_in_ready_low", 32'(a_ir), 32'd0);
        check("bp_hold_valid", 32'(a_ov), 32'd1);
        check("bp_hold_data", 32'(a_od), 32'h00000A01);
        step();
        check("bp_stall_in_ready", 32'(a_ir), 32'd0);
        check("bp_stall_data", 32'(a_od), 32'h00000A01);
        check("bp_stall_sel", 32'(a_os), 32'd1);
        check("bp_stall_valid", 32'(a_ov), 32'd1);
        a_or = 1'b1;
        step();
        check("bp_skid_to_main", 32'(a_od), 32'h00000B03);
        check("bp_in_ready_back", 32'(a_ir), 32'd1);
        step();
        a_iv = 1'b0;
        check("bp_third_beat", 32'(a_od), 32'h00000C00);
        step();
        check("bp_all_drained", 32'(a_ov), 32'd0);
        check("bp_queue_empty", 32'(qa.size()), 32'd0);

        // Flush with main and skid full and input offered
        a_or = 1'b0;
        a_data = {16'h1113, 16'h1112, 16'h1111, 16'h1110}; a_sel = 2'd0; a_iv = 1'b1;
        step();
        a_sel = 2'd1;
        step();
        a_sel = 2'd2; a_fl = 1'b1;
        step();
        a_fl = 1'b0; a_iv = 1'b0;
        check("flush_out_valid", 32'(a_ov), 32'd0);
        check("flush_in_ready", 32'(a_ir), 32'd1);
        a_iv = 1'b1; a_sel = 2'd3;
        step();
        check("flush2_loaded", 32'(a_ov), 32'd1);
        a_sel = 2'd2; a_fl = 1'b1;
        step();
        a_fl = 1'b0; a_iv = 1'b0;
        check("flush2_out_valid", 32'(a_ov), 32'd0);
        check("flush2_in_ready", 32'(a_ir), 32'd1);
        a_or = 1'b1;
        step();
        step();
        check("flush_no_ghost", 32'(a_ov), 32'd0);

        // Async reset mid-transfer
        a_or = 1'b0; a_sel = 2'd1; a_iv = 1'b1;
        a_data = {16'h2223, 16'h2222, 16'h2221, 16'h2220};
        step();
        a_sel = 2'd2;
        step();
        a_iv = 1'b0;
        check("pre_rst_valid", 32'(a_ov), 32'd1);
        check("pre_rst_in_ready", 32'(a_ir), 32'd0);
        #2 arst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(a_ov), 32'd0);
        check("arst_in_ready", 32'(a_ir), 32'd1);
        check("arst_out_data", 32'(a_od), 32'd0);
        check("arst_out_sel", 32'(a_os), 32'd0);
        #3 arst_n = 1'b1;
        step();
        a_iv = 1'b1; a_sel = 2'd3;
        step();
        a_iv = 1'b0; a_or = 1'b1;
        check("post_rst_accept", 32'(a_ov), 32'd1);
        check("post_rst_data", 32'(a_od), 32'h00002223);
        step();
        check("post_rst_drained", 32'(a_ov), 32'd0);

        // Out-of-range binary select and one-hot decoding
        bc_or = 1'b1; bc_iv = 1'b1; b_sel = 2'd3; c_sel = 4'b0110;
        step();
        check("b_oor_data", 32'(b_od), 32'h0000B0B0);
        check("b_oor_sel", 32'(b_os), 32'd3);
        check("c_0110_data", 32'(c_od), 32'h0000C1C1);
        check("c_0110_sel", 32'(c_os), 32'd6);
        b_sel = 2'd2; c_sel = 4'b0000;
        step();
        check("b_sel2_data", 32'(b_od), 32'h0000B2B2);
        check("c_zero_data", 32'(c_od), 32'h0000C0C0);
        b_sel = 2'd1; c_sel = 4'b1000;
        step();
        check("b_sel1_data", 32'(b_od), 32'h0000B1B1);
        check("c_1000_data", 32'(c_od), 32'h0000C3C3);
        check("bc_valid", 32'({b_ov, c_ov}), 32'd3);
        bc_iv = 1'b0;
        step();
        check("bc_drained", 32'({b_ov, c_ov}), 32'd0);

        // Streaming at one beat per cycle over N_IN=8
        d_or = 1'b1; d_iv = 1'b1;
        for (int k = 0; k < 8; k++) begin
            d_sel = 3'(k);
            check("d_in_ready", 32'(d_ir), 32'd1);
            step();
            check("d_out_valid", 32'(d_ov), 32'd1);
        end
        d_iv = 1'b0;
        step();
        check("d_stream_end", 32'(d_ov), 32'd0);
        check("d_pop_count", 32'(d_pops), 32'd8);
        check("d_queue_empty", 32'(qd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
